muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit holding the architectural HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the next-generation core. The core issues an operation with a start pulse and stalls on busy.
- Results become visible on hi/lo, which the core reads for MFHI/MFLO.
- Radix-2, one result bit per cycle; WIDTH generalises the datapath beyond 32 bits.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add / restoring shift-subtract step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] part,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] part_next,
    output logic             q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: in_bit is the multiplier LSB and q_bit is the product bit shifted into low.
    // Divide: in_bit is the next dividend bit and q_bit is the quotient bit.
    always_comb begin
        sum     = {1'b0, part} + (in_bit ? {1'b0, operand} : '0);
        shifted = {part, in_bit};
        ge      = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            q_bit     = ge;
            part_next = ge ? diff : shifted[WIDTH-1:0];
        end else begin
            q_bit     = sum[0];
            part_next = sum[WIDTH:1];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO pair
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             dz;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] opnd;

    logic             load;
    logic             a_neg;
    logic             b_neg;
    logic             ld_dz;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             in_bit;
    logic [WIDTH-1:0] part_next;
    logic             q_bit;
    logic [WIDTH-1:0] low_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    assign busy = (state == ST_RUN);

    always_comb begin
        load  = start && ((state == ST_IDLE) || ((state == ST_FIN) && !flush));
        a_neg = op[0] & operand_a[WIDTH-1];
        b_neg = op[0] & operand_b[WIDTH-1];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
        ld_dz = op[1] && (operand_b == '0);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div),
        .part      (acc),
        .in_bit    (in_bit),
        .operand   (opnd),
        .part_next (part_next),
        .q_bit     (q_bit)
    );

    always_comb begin
        in_bit   = is_div ? low[WIDTH-1] : low[0];
        low_next = is_div ? {low[WIDTH-2:0], q_bit} : {q_bit, low[WIDTH-1:1]};
        prod     = neg_lo ? -{acc, low} : {acc, low};
        if (dz) begin
            // Divide by zero keeps the raw dividend in low for HI.
            hi_n = low;
            lo_n = '1;
        end else if (is_div) begin
            hi_n = neg_hi ? -acc : acc;
            lo_n = neg_lo ? -low : low;
        end else begin
            hi_n = prod[2*WIDTH-1:WIDTH];
            lo_n = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            acc         <= '0;
            low         <= '0;
            opnd        <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!start) begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= part_next;
                        low <= low_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        hi   <= hi_n;
                        lo   <= lo_n;
                        done <= 1'b1;
                        if (is_div) div_by_zero <= dz;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (load) begin
                state  <= ld_dz ? ST_FIN : ST_RUN;
                cnt    <= CW'(WIDTH);
                is_div <= op[1];
                dz     <= ld_dz;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= op[1] ? a_neg : (a_neg ^ b_neg);
                acc    <= '0;
                low    <= ld_dz ? operand_a : a_mag;
                opnd   <= b_mag;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic          flush = 1'b0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_fail = 0;
    logic exp_dz = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sa, sb, sq, sr;
        logic [63:0] p, q64, r64;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        eh = '0;
        el = '0;
        if (o[1] && b == 0) begin
            eh = a;
            el = '1;
        end else if (o == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            {eh, el} = p;
        end else if (o == OP_MULT) begin
            p = sa * sb;
            {eh, el} = p;
        end else if (o == OP_DIVU) begin
            el = a / b;
            eh = a % b;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            q64 = sq;
            r64 = sr;
            el = q64[31:0];
            eh = r64[31:0];
        end
    endtask

    task automatic kick(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        int cyc, bc, lat;
        model(o, a, b, eh, el);
        lat = (o[1] && b == 0) ? 1 : W + 1;
        if (o[1]) exp_dz = (b == 0);
        kick(o, a, b);
        wait_done(cyc, bc);
        check_eq({tag, "_latency"}, cyc, lat);
        check_eq({tag, "_busy_cycles"}, bc, lat - 1);
        check_eq({tag, "_hi"}, hi, eh);
        check_eq({tag, "_lo"}, lo, el);
        check_eq({tag, "_dz"}, div_by_zero, exp_dz);
    endtask

    initial begin
        int cyc, bc, sel, seen;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        #22;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dz", div_by_zero, 0);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max_hi_const", hi, 64'hFFFF_FFFE);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_neg_lo_const", lo, 64'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0);
        run_op("divu_7", OP_DIVU, 32'd100, 32'd7);
        check_eq("divu_7_lo_const", lo, 64'd14);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero_signed", OP_DIV, 32'hFFFF_FF00, 32'd0);
        run_op("mult_after_dz", OP_MULT, 32'd3, 32'hFFFF_FFFF);

        // MTHI / MTLO
        @(negedge clk);
        hi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mthi", hi, 32'h1234);
        check_eq("mtlo", lo, 32'h5678);

        // Flush mid-RUN: no done, hi/lo untouched
        kick(OP_MULTU, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            seen += int'(done);
            @(negedge clk);
        end
        check_eq("flush_no_done", seen, 0);
        check_eq("flush_hi", hi, 32'h1234);
        check_eq("flush_lo", lo, 32'h5678);
        check_eq("flush_dz", div_by_zero, exp_dz);

        // Start while busy is ignored
        kick(OP_MULTU, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MULTU; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        check_eq("ignored_start_latency", cyc, W + 1 - 5);
        check_eq("ignored_start_lo", lo, 32'd30);
        check_eq("ignored_start_hi", hi, 0);

        // Back-to-back start in FIN
        kick(OP_MULTU, 32'd2, 32'd3);
        repeat (W) @(negedge clk);
        check_eq("b2b_fin_busy", busy, 0);
        start = 1'b1; op = OP_MULTU; operand_a = 32'd4; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_done1", done, 1);
        check_eq("b2b_lo1", lo, 32'd6);
        @(negedge clk);
        wait_done(cyc, bc);
        check_eq("b2b_latency2", cyc + 1, W + 1);
        check_eq("b2b_lo2", lo, 32'd20);

        // Asynchronous reset mid-RUN
        run_op("pre_rst_dz", OP_DIVU, 32'd55, 32'd0);
        kick(OP_MULT, 32'd77, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_dz", div_by_zero, 0);
        check_eq("arst_hi", hi, 0);
        check_eq("arst_lo", lo, 0);
        exp_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = '1; end
            else if (sel == 2) rb = 32'($urandom_range(1, 20));
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
